// File: rtl/blastn_seq_streamer.sv
// blastn_seq_streamer: feeds a query, then subject characters, then pad flush into the Blastn systolic array.
// Enables are registered one cycle after issue; the datastreams gate the 1-cycle-latency RAM data with them.
module blastn_seq_streamer #(
    parameter int LENGTH_CHAR    = 3,
    parameter int LENGTH         = 32,
    parameter int LENGTH_COUNTER = 8
) (
    input  logic                      array_clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stall,
    input  logic [LENGTH_COUNTER-1:0] sub_length,
    output logic [LENGTH_COUNTER-1:0] q_rd_addr,
    input  logic [LENGTH_CHAR-1:0]    q_rd_data,
    output logic [LENGTH_COUNTER-1:0] s_rd_addr,
    input  logic [LENGTH_CHAR-1:0]    s_rd_data,
    output logic [LENGTH_CHAR-1:0]    query_datastream,
    output logic [LENGTH_CHAR-1:0]    sub_datastream,
    output logic                      query_enable,
    output logic                      sub_enable,
    output logic                      enable,
    output logic                      busy,
    output logic                      done
);
    localparam logic [LENGTH_COUNTER-1:0] LAST = LENGTH_COUNTER'(LENGTH - 1);
    localparam logic [LENGTH_COUNTER-1:0] ONE  = LENGTH_COUNTER'(1);

    typedef enum logic [2:0] {IDLE, LOAD_Q, STREAM_S, FLUSH, DONE} state_t;

    state_t                    state_q;
    logic [LENGTH_COUNTER-1:0] n_q, q_addr_q, s_addr_q, cnt_q;
    logic                      qv_q, sv_q, pad_q, done_q;
    logic                      issue;

    assign issue = (state_q == LOAD_Q || state_q == STREAM_S || state_q == FLUSH) && !stall;

    always_ff @(posedge array_clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            n_q      <= '0;
            q_addr_q <= '0;
            s_addr_q <= '0;
            cnt_q    <= '0;
            qv_q     <= 1'b0;
            sv_q     <= 1'b0;
            pad_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            qv_q   <= issue && state_q == LOAD_Q;
            sv_q   <= issue && (state_q == STREAM_S || state_q == FLUSH);
            pad_q  <= issue && state_q == FLUSH;
            done_q <= state_q == DONE;
            case (state_q)
                IDLE: begin
                    // the done cycle already sits in IDLE, so a start there must be refused explicitly
                    if (start && !done_q) begin
                        n_q      <= sub_length;
                        q_addr_q <= '0;
                        s_addr_q <= '0;
                        cnt_q    <= '0;
                        state_q  <= (sub_length == '0) ? DONE : LOAD_Q;
                    end
                end
                LOAD_Q: begin
                    if (issue) begin
                        if (q_addr_q == LAST) state_q <= STREAM_S;
                        else q_addr_q <= q_addr_q + ONE;
                    end
                end
                STREAM_S: begin
                    if (issue) begin
                        if (s_addr_q == n_q - ONE) state_q <= FLUSH;
                        else s_addr_q <= s_addr_q + ONE;
                    end
                end
                FLUSH: begin
                    if (issue) begin
                        if (cnt_q == LAST) state_q <= DONE;
                        else cnt_q <= cnt_q + ONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign q_rd_addr        = q_addr_q;
    assign s_rd_addr        = s_addr_q;
    assign query_enable     = qv_q;
    assign sub_enable       = sv_q;
    assign enable           = sv_q;
    assign done             = done_q;
    assign busy             = state_q != IDLE;
    assign query_datastream = qv_q ? q_rd_data : '0;
    assign sub_datastream   = (sv_q && !pad_q) ? s_rd_data : '0;
endmodule

// File: tb/tb_blastn_seq_streamer.sv
// tb_blastn_seq_streamer: directed jobs against a scoreboard; a negedge monitor pops expected characters and done cycles.
module tb_blastn_seq_streamer;
    localparam int LC = 3;
    localparam int L  = 32;
    localparam int W  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic [W-1:0]  sub_length = '0;
    logic [W-1:0]  q_rd_addr, s_rd_addr;
    logic [LC-1:0] q_rd_data, s_rd_data, qds, sds;
    logic          qen, sen, en, busy, done;
    logic [LC-1:0] q_mem [256];
    logic [LC-1:0] s_mem [256];

    typedef struct {int ch; int addr; bit pad;} ev_t;
    ev_t qexp[$];
    ev_t sexp[$];
    int  dexp[$];
    int  checks = 0, fails = 0, cyc = 0, qn = 0, sn = 0, bn = 0, prev_q = 0, prev_s = 0;
    bit  done_seen = 0;

    blastn_seq_streamer #(.LENGTH_CHAR(LC), .LENGTH(L), .LENGTH_COUNTER(W)) dut (
        .array_clk(clk), .reset(rst_n), .start(start), .stall(stall), .sub_length(sub_length),
        .q_rd_addr(q_rd_addr), .q_rd_data(q_rd_data), .s_rd_addr(s_rd_addr), .s_rd_data(s_rd_data),
        .query_datastream(qds), .sub_datastream(sds), .query_enable(qen), .sub_enable(sen),
        .enable(en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        q_rd_data <= q_mem[q_rd_addr];
        s_rd_data <= s_mem[s_rd_addr];
    end

    function automatic int qch(int i);
        return (i % 4) + 1;
    endfunction

    function automatic int sch(int i);
        return ((i * 5 + i / 3) % 4) + 1;
    endfunction

    function void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d at cycle %0d", nm, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        ev_t e;
        if (qen && sen) chk("enable_overlap", 1, 0);
        if (en !== sen) chk("enable_eq_sub_enable", int'(en), int'(sen));
        if (qen) begin
            qn++;
            if (qexp.size() == 0) chk("q_extra_enable", 1, 0);
            else begin
                e = qexp.pop_front();
                chk("q_char", int'(qds), e.ch);
                chk("q_addr", prev_q, e.addr);
            end
        end
        if (sen) begin
            sn++;
            if (sexp.size() == 0) chk("s_extra_enable", 1, 0);
            else begin
                e = sexp.pop_front();
                chk("s_char", int'(sds), e.ch);
                if (!e.pad) chk("s_addr", prev_s, e.addr);
            end
        end
        if (done) begin
            if (dexp.size() == 0) chk("done_unexpected", 1, 0);
            else chk("done_cycle", cyc, dexp.pop_front());
            done_seen = 1;
        end
        if (busy) bn++;
        prev_q = int'(q_rd_addr);
        prev_s = int'(s_rd_addr);
    end

    task automatic push_job(input int n, input int c0, input int exp_done);
        if (n > 0) begin
            for (int i = 0; i < L; i++) qexp.push_back('{qch(i), i, 1'b0});
            for (int i = 0; i < n; i++) sexp.push_back('{sch(i), i, 1'b0});
            for (int i = 0; i < L; i++) sexp.push_back('{0, 0, 1'b1});
        end
        dexp.push_back(c0 + exp_done);
    endtask

    task automatic run_job(input int n, input int sa, input int sb, input int sc, input int sd,
                           input int rs, input int exp_done);
        @(posedge clk);
        #1;
        done_seen = 0;
        qn = 0;
        sn = 0;
        bn = 0;
        push_job(n, cyc, exp_done);
        start = 1'b1;
        sub_length = W'(n);
        stall = 1'b0;
        for (int r = 1; r < exp_done + 20 && !done_seen; r++) begin
            @(posedge clk);
            #1;
            start = (r == rs);
            sub_length = (r == rs) ? W'(n + 4) : W'(n);
            stall = (r >= sa && r <= sb) || (r >= sc && r <= sd);
            @(negedge clk);
            #1;
        end
        start = 1'b0;
        stall = 1'b0;
        chk("done_seen", int'(done_seen), 1);
        chk("q_enable_count", qn, (n > 0) ? L : 0);
        chk("s_enable_count", sn, (n > 0) ? n + L : 0);
        chk("busy_cycles", bn, exp_done - 1);
        chk("q_queue_drained", qexp.size(), 0);
        chk("s_queue_drained", sexp.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            q_mem[i] = LC'(qch(i));
            s_mem[i] = LC'(sch(i));
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_qen", int'(qen), 0);
        chk("rst_sen", int'(sen), 0);
        chk("rst_q_addr", int'(q_rd_addr), 0);
        chk("rst_s_addr", int'(s_rd_addr), 0);
        rst_n = 1'b1;

        run_job(5, 0, -1, 0, -1, -1, 2 * L + 5 + 2);
        run_job(0, 0, -1, 0, -1, -1, 2);
        run_job(5, 10, 14, 36, 37, -1, 78);
        run_job(5, 0, -1, 0, -1, 35, 2 * L + 5 + 2);

        @(posedge clk);
        #1;
        push_job(5, cyc, 71);
        start = 1'b1;
        sub_length = W'(5);
        for (int r = 1; r <= 20; r++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_qen", int'(qen), 0);
        chk("async_sen", int'(sen), 0);
        chk("async_enable", int'(en), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_done", int'(done), 0);
        chk("async_qds", int'(qds), 0);
        chk("async_q_addr", int'(q_rd_addr), 0);
        qexp.delete();
        sexp.delete();
        dexp.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_busy", int'(busy), 0);

        run_job(5, 0, -1, 0, -1, -1, 2 * L + 5 + 2);
        run_job(255, 0, -1, 0, -1, -1, 321);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
